// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SDRAM arbiter.
package wshb_arb_pkg;

    // Arbiter ownership state; GNT0 = VGA reader, GNT1 = pattern/frame writer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // The SDRAM slave only ever sees classic single transfers.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller.
// M0 is the VGA frame reader, M1 the pattern/frame writer. Ownership is held
// for a whole Wishbone cycle (cyc) and handed over round-robin; a burst cap
// forces a hand-over after MAX_BURST acks when the other master is waiting.
//
// Handshake: a transfer completes on a clock edge where the granted master's
// stb is high and s_ack is high. The arbiter adds no storage on the data path,
// so while a master owns the port its request reaches the slave and the ack
// comes back in the same cycle. A non-granted master sees no ack and simply
// holds its request until it is granted.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_ms,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic [31:0] m0_dat_sm,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_ms,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic [31:0] m1_dat_sm,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_ms,
    output logic [3:0]  s_sel,
    output logic [2:0]  s_cti,
    output logic [1:0]  s_bte,
    input  logic        s_ack,
    input  logic [31:0] s_dat_sm,
    output logic [1:0]  grant
);

    // Ack count at which the owner must yield if the other master is waiting.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             rr_ptr;      // 0: M0 wins a tie, 1: M1 wins a tie
    logic             rr_nxt;
    logic [CNT_W-1:0] ack_cnt;

    // State and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Ack counter: restarts on every ownership change, saturates at the cap so
    // a lone master can run forever and still yields on the next ack once the
    // other master shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state_nxt != state) begin
            ack_cnt <= '0;
        end else if (state != IDLE && s_ack && ack_cnt != CNT_LAST) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    // Next-state decision: end of cycle hands over, cap preempts only on an ack.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = rr_ptr ? GNT1 : GNT0;
                end else if (m0_cyc) begin
                    state_nxt = GNT0;
                end else if (m1_cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_nxt = m1_cyc ? GNT1 : IDLE;
                    rr_nxt    = 1'b1;
                end else if (s_ack && ack_cnt == CNT_LAST && m1_cyc) begin
                    state_nxt = GNT1;
                    rr_nxt    = 1'b1;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_nxt = m0_cyc ? GNT0 : IDLE;
                    rr_nxt    = 1'b0;
                end else if (s_ack && ack_cnt == CNT_LAST && m0_cyc) begin
                    state_nxt = GNT0;
                    rr_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output mux driven only by the registered owner, so a master that just
    // lost the grant is never forwarded in the hand-over cycle.
    always_comb begin
        grant    = 2'b00;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        case (state)
            GNT0: begin
                grant    = 2'b01;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
            end
            GNT1: begin
                grant    = 2'b10;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
            end
            default: begin
            end
        endcase
    end

    // Acks only reach the owner; a stray ack while idle goes nowhere.
    assign m0_ack    = s_ack & grant[0];
    assign m1_ack    = s_ack & grant[1];
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
    assign s_cti     = CTI_CLASSIC;
    assign s_bte     = BTE_LINEAR;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: one instance with the default burst cap
// (64) and one with a cap of 4, both fed the same master/slave stimulus.
module tb_wshb_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms;
  logic [3:0]  m1_sel;
  logic        s_ack;
  logic [31:0] s_dat_sm;

  // Outputs of the MAX_BURST=64 instance
  logic        m0_ack, m1_ack;
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant;

  // Outputs of the MAX_BURST=4 instance
  logic        b_m0_ack, b_m1_ack;
  logic [31:0] b_m0_dat_sm, b_m1_dat_sm;
  logic        b_s_cyc, b_s_stb, b_s_we;
  logic [31:0] b_s_adr, b_s_dat_ms;
  logic [3:0]  b_s_sel;
  logic [2:0]  b_s_cti;
  logic [1:0]  b_s_bte;
  logic [1:0]  b_grant;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  wshb_arbiter #(.MAX_BURST(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm), .grant(grant)
  );

  wshb_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(b_m0_ack), .m0_dat_sm(b_m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(b_m1_ack), .m1_dat_sm(b_m1_dat_sm),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
    .s_dat_ms(b_s_dat_ms), .s_sel(b_s_sel), .s_cti(b_s_cti), .s_bte(b_s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm), .grant(b_grant)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled 1 unit after that, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
    s_ack = 0; s_dat_sm = '0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    s_ack = 1;
    repeat (2) tick();
    n_checks++;
    if ({grant, s_cyc, s_stb, s_we, m0_ack, m1_ack} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack});
    end
    n_checks++;
    if ({s_adr, s_dat_ms, s_sel, s_cti, s_bte} !== 73'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {s_adr, s_dat_ms, s_sel, s_cti, s_bte});
    end
    n_checks++;
    if ({b_grant, b_m0_ack, b_m1_ack, b_s_cyc} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_cap4: got %b expected 00000", {b_grant, b_m0_ack, b_m1_ack, b_s_cyc});
    end
    s_ack = 0;
    rst = 0;
    tick();
  endtask

  task automatic test_reset_mid_gnt1();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2000;
    m1_dat_ms = 32'hDEAD_BEEF; m1_sel = 4'hF;
    settle();
    n_checks++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rst_latency: got %b expected 000", {grant, s_cyc});
    end
    tick();
    n_checks++;
    if ({grant, s_cyc, s_stb, s_we, s_adr} !== {2'b10, 3'b111, 32'h0000_2000}) begin
      n_fail++;
      $display("FAIL mid_rst_granted: got %h expected %h", {grant, s_cyc, s_stb, s_we, s_adr}, {2'b10, 3'b111, 32'h0000_2000});
    end
    s_ack = 1;
    settle();
    n_checks++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rst_ack: got %b expected 10", {m1_ack, m0_ack});
    end
    rst = 1;
    settle();
    n_checks++;
    if ({grant, s_cyc, s_stb, m1_ack, m0_ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_rst_async: got %b expected 000000", {grant, s_cyc, s_stb, m1_ack, m0_ack});
    end
    tick();
    n_checks++;
    if ({grant, s_cyc, m1_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rst_held: got %b expected 0000", {grant, s_cyc, m1_ack});
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_m0_reads();
    int acks0 = 0;
    int acks1 = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h0000_1000;
    settle();
    n_checks++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_fail++;
      $display("FAIL m0_idle_latency: got %b expected 000", {grant, s_cyc});
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      m0_adr   = 32'h0000_1000 + 32'(4 * i);
      s_dat_sm = 32'hC0DE_0000 + 32'(i);
      s_ack    = 1;
      settle();
      acks0 += int'(m0_ack);
      acks1 += int'(m1_ack);
      n_checks++;
      if ({grant, s_cyc, s_stb, s_we, m0_ack, m1_ack} !== 7'b01_110_10) begin
        n_fail++;
        $display("FAIL m0_read_ctrl[%0d]: got %b expected 0111010", i, {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack});
      end
      n_checks++;
      if (s_adr !== 32'h0000_1000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL m0_read_adr[%0d]: got %h expected %h", i, s_adr, 32'h0000_1000 + 32'(4 * i));
      end
      n_checks++;
      if ({m0_dat_sm, m1_dat_sm} !== {2{32'hC0DE_0000 + 32'(i)}}) begin
        n_fail++;
        $display("FAIL m0_read_dat[%0d]: got %h expected %h", i, {m0_dat_sm, m1_dat_sm}, {2{32'hC0DE_0000 + 32'(i)}});
      end
      tick();
    end
    n_checks++;
    if ({acks0, acks1} !== {32'd10, 32'd0}) begin
      n_fail++;
      $display("FAIL m0_read_count: got m0=%0d m1=%0d expected m0=10 m1=0", acks0, acks1);
    end
    clear_inputs();
    settle();
    n_checks++;
    if ({grant, s_cyc} !== 3'b010) begin
      n_fail++;
      $display("FAIL m0_drop_cyc: got %b expected 010", {grant, s_cyc});
    end
    tick();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL m0_back_idle: got %b expected 00", grant);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_A000; m0_sel = 4'h3;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_B000; m1_sel = 4'hC;
    m1_dat_ms = 32'h1234_5678;
    tick();
    n_checks++;
    if ({grant, s_adr, s_sel, s_we} !== {2'b01, 32'h0000_A000, 4'h3, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_first: got %h expected %h", {grant, s_adr, s_sel, s_we}, {2'b01, 32'h0000_A000, 4'h3, 1'b0});
    end
    s_ack = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if ({m0_ack, m1_ack} !== 2'b10) begin
        n_fail++;
        $display("FAIL simul_m0_ack[%0d]: got %b expected 10", i, {m0_ack, m1_ack});
      end
      tick();
    end
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    settle();
    n_checks++;
    if ({grant, s_cyc, s_stb} !== 4'b0100) begin
      n_fail++;
      $display("FAIL simul_handover_cycle: got %b expected 0100", {grant, s_cyc, s_stb});
    end
    tick();
    s_ack = 1;
    settle();
    n_checks++;
    if ({grant, s_cyc, s_stb, s_we, m0_ack, m1_ack} !== 7'b10_111_01) begin
      n_fail++;
      $display("FAIL simul_m1_ctrl: got %b expected 1011101", {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack});
    end
    n_checks++;
    if ({s_adr, s_dat_ms, s_sel} !== {32'h0000_B000, 32'h1234_5678, 4'hC}) begin
      n_fail++;
      $display("FAIL simul_m1_data: got %h expected %h", {s_adr, s_dat_ms, s_sel}, {32'h0000_B000, 32'h1234_5678, 4'hC});
    end
    tick();
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_burst_cap();
    int b0 = 0;
    int b1 = 0;
    int a0 = 0;
    logic [1:0] e;
    pulse_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_00A0;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_00B0;
    tick();
    for (int k = 0; k < 24; k++)
      exp_q.push_back(((k / 4) % 2 == 1) ? 2'b10 : 2'b01);
    for (int k = 0; k < 24; k++) begin
      s_ack = 1;
      settle();
      e = exp_q.pop_front();
      b0 += int'(b_m0_ack);
      b1 += int'(b_m1_ack);
      a0 += int'(m0_ack);
      n_checks++;
      if ({b_grant, b_m1_ack, b_m0_ack} !== {e, e}) begin
        n_fail++;
        $display("FAIL cap4_grant[%0d]: got %b expected %b", k, {b_grant, b_m1_ack, b_m0_ack}, {e, e});
      end
      n_checks++;
      if (b_s_adr !== (e[0] ? 32'h0000_00A0 : 32'h0000_00B0)) begin
        n_fail++;
        $display("FAIL cap4_adr[%0d]: got %h expected %h", k, b_s_adr, (e[0] ? 32'h0000_00A0 : 32'h0000_00B0));
      end
      n_checks++;
      if ({grant, m1_ack} !== 3'b010) begin
        n_fail++;
        $display("FAIL cap64_hold[%0d]: got %b expected 010", k, {grant, m1_ack});
      end
      tick();
    end
    n_checks++;
    if ({b0, b1, a0} !== {32'd12, 32'd12, 32'd24}) begin
      n_fail++;
      $display("FAIL cap_counts: got b0=%0d b1=%0d a0=%0d expected 12 12 24", b0, b1, a0);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_saturation();
    int acks1 = 0;
    pulse_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_3000;
    tick();
    for (int k = 0; k < 200; k++) begin
      s_ack = 1;
      settle();
      acks1 += int'(m1_ack);
      n_checks++;
      if ({grant, m1_ack, m0_ack, b_grant} !== 6'b10_10_10) begin
        n_fail++;
        $display("FAIL sat_lone_m1[%0d]: got %b expected 101010", k, {grant, m1_ack, m0_ack, b_grant});
      end
      tick();
    end
    n_checks++;
    if (acks1 !== 200) begin
      n_fail++;
      $display("FAIL sat_count: got %0d expected 200", acks1);
    end
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_4000;
    settle();
    n_checks++;
    if ({grant, b_grant, m0_ack, s_we, s_adr} !== {4'b1010, 1'b0, 1'b1, 32'h0000_3000}) begin
      n_fail++;
      $display("FAIL sat_m0_waits: got %h expected %h", {grant, b_grant, m0_ack, s_we, s_adr}, {4'b1010, 1'b0, 1'b1, 32'h0000_3000});
    end
    tick();
    n_checks++;
    if ({grant, b_grant} !== 4'b1010) begin
      n_fail++;
      $display("FAIL sat_no_ack_no_switch: got %b expected 1010", {grant, b_grant});
    end
    s_ack = 1;
    settle();
    n_checks++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL sat_last_ack: got %b expected 10", {m1_ack, m0_ack});
    end
    tick();
    s_ack = 0;
    settle();
    n_checks++;
    if ({grant, b_grant, s_we, s_adr} !== {4'b0101, 1'b0, 32'h0000_4000}) begin
      n_fail++;
      $display("FAIL sat_switch: got %h expected %h", {grant, b_grant, s_we, s_adr}, {4'b0101, 1'b0, 32'h0000_4000});
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_ack_in_idle();
    for (int k = 0; k < 3; k++) begin
      s_ack = 1;
      settle();
      n_checks++;
      if ({grant, b_grant, m0_ack, m1_ack, b_m0_ack, b_m1_ack, s_cyc} !== 9'b0) begin
        n_fail++;
        $display("FAIL idle_ack[%0d]: got %b expected 000000000", k, {grant, b_grant, m0_ack, m1_ack, b_m0_ack, b_m1_ack, s_cyc});
      end
      tick();
    end
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    settle();
    n_checks++;
    if ({grant, b_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_still_idle: got %b expected 0000", {grant, b_grant});
    end
    tick();
    n_checks++;
    if ({grant, b_grant} !== 4'b0101) begin
      n_fail++;
      $display("FAIL idle_then_grant: got %b expected 0101", {grant, b_grant});
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_reset_mid_gnt1();
    test_m0_reads();
    test_simultaneous();
    test_burst_cap();
    test_saturation();
    test_ack_in_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    if (n_fail == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
